// File: rtl/load_rd_queue_if.sv
// Issue / write-back / hazard-query bundle between decode, the load rd queue
// and the register-file write port.
interface load_rd_queue_if #(
    parameter int DEPTH    = 4,
    parameter int REG_BITS = 5,
    parameter int NUM_REGS = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                issue_valid;
    logic [REG_BITS-1:0] issue_rd;
    logic                issue_ready;
    logic                resp_valid;
    logic [REG_BITS-1:0] wb_rd_in;
    logic [REG_BITS-1:0] wb_rd;
    logic                wb_is_load;
    logic                flush;
    logic [REG_BITS-1:0] query_rs1;
    logic [REG_BITS-1:0] query_rs2;
    logic                hazard;
    logic [NUM_REGS-1:0] pending_mask;
    logic [CNT_W-1:0]    count;
    logic                underflow_err;

    modport master (
        output issue_valid, issue_rd, resp_valid, wb_rd_in, flush, query_rs1, query_rs2,
        input  issue_ready, wb_rd, wb_is_load, hazard, pending_mask, count, underflow_err
    );

    modport slave (
        input  issue_valid, issue_rd, resp_valid, wb_rd_in, flush, query_rs1, query_rs2,
        output issue_ready, wb_rd, wb_is_load, hazard, pending_mask, count, underflow_err
    );
endinterface

// File: rtl/load_rd_queue.sv
// In-order queue of destination registers for outstanding loads, with
// same-cycle bypass, flush, pending-register scoreboard and sticky underflow flag.
module load_rd_queue #(
    parameter int DEPTH    = 4,
    parameter int REG_BITS = 5,
    parameter int NUM_REGS = 32
) (
    input logic           clk,
    input logic           rst_n,
    load_rd_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [CNT_W-1:0]    cnt;
    logic                uflow;

    logic                empty;
    logic                full;
    logic                pop;
    logic                bypass;
    logic                push;
    logic                noMatch;
    logic [NUM_REGS-1:0] mask;
    logic [PTR_W-1:0]    idx;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign pop     = bus.resp_valid && !empty;
    assign bypass  = bus.resp_valid && empty && bus.issue_valid;
    assign noMatch = bus.resp_valid && empty && !bus.issue_valid;
    // A bypassed load is consumed this cycle, so it never occupies a slot.
    assign push    = bus.issue_valid && !full && !bypass && !bus.flush;

    always_comb begin
        bus.wb_rd      = bus.wb_rd_in;
        bus.wb_is_load = 1'b0;
        if (pop) begin
            bus.wb_rd      = mem[rptr];
            bus.wb_is_load = 1'b1;
        end else if (bypass) begin
            bus.wb_rd      = bus.issue_rd;
            bus.wb_is_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            uflow <= 1'b0;
        end else begin
            uflow <= uflow | noMatch;
            if (bus.flush) begin
                cnt  <= '0;
                rptr <= wptr;
            end else begin
                if (push) wptr <= wptr + PTR_W'(1);
                if (pop)  rptr <= rptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Entry storage holds data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.issue_rd;
    end

    // Walk the live window from head; register 0 is never reported pending.
    always_comb begin
        mask = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PTR_W'(i);
            if ((CNT_W'(i) < cnt) && (int'(mem[idx]) < NUM_REGS))
                mask[mem[idx]] = 1'b1;
        end
        mask[0] = 1'b0;
    end

    assign bus.pending_mask  = mask;
    assign bus.hazard        = mask[bus.query_rs1] | mask[bus.query_rs2];
    assign bus.issue_ready   = !full;
    assign bus.count         = cnt;
    assign bus.underflow_err = uflow;
endmodule

// File: tb/tb_load_rd_queue.sv
// Directed and randomized bench for load_rd_queue against a queue-based model.
module tb_load_rd_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [4:0] q[$];
    logic       mUflow;

    logic [4:0] owb;
    logic       oload;
    logic       ohaz;

    load_rd_queue_if #(.DEPTH(DEPTH), .REG_BITS(5), .NUM_REGS(32)) bus ();

    load_rd_queue #(.DEPTH(DEPTH), .REG_BITS(5), .NUM_REGS(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelMask();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i] != 5'd0) m[q[i]] = 1'b1;
        return m;
    endfunction

    // One clock cycle: drive, compare combinational outputs, clock, update model.
    task automatic cyc(input logic iv, input logic [4:0] ird, input logic rv,
                       input logic [4:0] win, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2,
                       output logic [4:0] wbOut, output logic ldOut, output logic hzOut);
        logic [4:0]  ewb;
        logic        eld;
        logic [31:0] em;
        int          sz;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.resp_valid  = rv;
        bus.wb_rd_in    = win;
        bus.flush       = fl;
        bus.query_rs1   = r1;
        bus.query_rs2   = r2;
        #1;
        sz = q.size();
        em = modelMask();
        if (rv && sz > 0) begin
            ewb = q[0];
            eld = 1'b1;
        end else if (rv && iv) begin
            ewb = ird;
            eld = 1'b1;
        end else begin
            ewb = win;
            eld = 1'b0;
        end
        chk("wb_rd", 32'(bus.wb_rd), 32'(ewb));
        chk("wb_is_load", 32'(bus.wb_is_load), 32'(eld));
        chk("pending_mask", bus.pending_mask, em);
        chk("hazard", 32'(bus.hazard), 32'(em[r1] | em[r2]));
        chk("count", 32'(bus.count), 32'(sz));
        chk("issue_ready", 32'(bus.issue_ready), 32'(sz < DEPTH));
        chk("underflow_err", 32'(bus.underflow_err), 32'(mUflow));
        wbOut = bus.wb_rd;
        ldOut = bus.wb_is_load;
        hzOut = bus.hazard;
        @(posedge clk);
        if (rv && sz == 0 && !iv) mUflow = 1'b1;
        if (fl) begin
            q.delete();
        end else begin
            if (rv && sz > 0) void'(q.pop_front());
            if (iv && sz < DEPTH && !(rv && sz == 0)) q.push_back(ird);
        end
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        cyc(1'b1, rd, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, owb, oload, ohaz);
    endtask

    task automatic resp(input logic [4:0] r1);
        cyc(1'b0, 5'd0, 1'b1, 5'd31, 1'b0, r1, 5'd0, owb, oload, ohaz);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mUflow   = 1'b0;
        rst_n    = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.resp_valid  = 1'b0;
        bus.wb_rd_in    = '0;
        bus.flush       = 1'b0;
        bus.query_rs1   = '0;
        bus.query_rs2   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset then idle
        chk("rst_mask", bus.pending_mask, 32'h0);
        chk("rst_hazard", 32'(bus.hazard), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_ready", 32'(bus.issue_ready), 32'h1);
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, owb, oload, ohaz);

        // In-order return of 5,6,7 with hazard on 6
        issue(5'd5); issue(5'd6); issue(5'd7);
        chk("mask_567", bus.pending_mask, 32'h0000_00E0);
        resp(5'd6); chk("seq_wb0", 32'(owb), 32'd5); chk("seq_ld0", 32'(oload), 32'd1); chk("seq_hz0", 32'(ohaz), 32'd1);
        resp(5'd6); chk("seq_wb1", 32'(owb), 32'd6); chk("seq_hz1", 32'(ohaz), 32'd1);
        resp(5'd6); chk("seq_wb2", 32'(owb), 32'd7); chk("seq_hz2", 32'(ohaz), 32'd0);
        chk("seq_mask_empty", bus.pending_mask, 32'h0);

        // Fill, issue while full, drain
        issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4);
        chk("full_ready", 32'(bus.issue_ready), 32'd0);
        issue(5'd9);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_bit9", 32'(bus.pending_mask[9]), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            resp(5'd0);
            chk("drain_order", 32'(owb), 32'(i));
        end

        // Zero-latency bypass
        cyc(1'b1, 5'd12, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, owb, oload, ohaz);
        chk("bypass_wb", 32'(owb), 32'd12);
        chk("bypass_ld", 32'(oload), 32'd1);
        chk("bypass_count", 32'(bus.count), 32'd0);

        // Simultaneous push and pop
        issue(5'd20); issue(5'd21);
        cyc(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, owb, oload, ohaz);
        chk("pp_wb", 32'(owb), 32'd20);
        chk("pp_count", 32'(bus.count), 32'd2);
        resp(5'd0); chk("pp_wb1", 32'(owb), 32'd21);
        resp(5'd0); chk("pp_wb2", 32'(owb), 32'd8);

        // Underflow, sticky through flush
        cyc(1'b0, 5'd0, 1'b1, 5'd17, 1'b0, 5'd0, 5'd0, owb, oload, ohaz);
        chk("uf_wb", 32'(owb), 32'd17);
        chk("uf_ld", 32'(oload), 32'd0);
        chk("uf_set", 32'(bus.underflow_err), 32'd1);
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, owb, oload, ohaz);
        chk("uf_after_flush", 32'(bus.underflow_err), 32'd1);

        // Register 0 entries and flush
        issue(5'd0); issue(5'd3);
        chk("r0_mask", bus.pending_mask, 32'h0000_0008);
        cyc(1'b1, 5'd25, 1'b0, 5'd0, 1'b1, 5'd3, 5'd0, owb, oload, ohaz);
        chk("fl_count", 32'(bus.count), 32'd0);
        chk("fl_mask", bus.pending_mask, 32'h0);
        issue(5'd10); issue(5'd11);
        resp(5'd0); chk("fl_next", 32'(owb), 32'd10);
        resp(5'd0);

        // Asynchronous reset with entries queued
        issue(5'd13); issue(5'd14); issue(5'd15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_mask", bus.pending_mask, 32'h0);
        chk("arst_uf", 32'(bus.underflow_err), 32'd0);
        chk("arst_ready", 32'(bus.issue_ready), 32'd1);
        q.delete();
        mUflow = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 19) == 0),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                owb, oload, ohaz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_rd_queue.md
Name: load_rd_queue

Overview:
- Tracks destination-register selects (rd) of outstanding loads so that each load result writes back to the correct register when it returns.
- Parametrised successor to the single-entry rd hold used by the single-cycle core: supports up to DEPTH in-order outstanding loads, zero-latency bypass, flush, a pending-register scoreboard for hazard checks, and an underflow error flag.
- Sits between decode/issue and the register-file write port of the CPU.

Parameters:
DEPTH, 4, maximum outstanding loads; power of two, >= 2.
REG_BITS, 5, width of a register select.
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
issue_valid  input  1  a load is issued this cycle.
issue_rd  input  REG_BITS  destination of the issuing load.
issue_ready  output  1  queue can accept a load: not full.
resp_valid  input  1  a load result is present on the writeback path this cycle.
wb_rd_in  input  REG_BITS  rd of the current non-load instruction.
wb_rd  output  REG_BITS  register select driven to the register-file write port.
wb_is_load  output  1  wb_rd belongs to a load result.
flush  input  1  discard all outstanding loads.
query_rs1  input  REG_BITS  source-register hazard query.
query_rs2  input  REG_BITS  source-register hazard query.
hazard  output  1  a query register is pending a load.
pending_mask  output  NUM_REGS  bit r set when any queued entry targets r, r != 0.
count  output  $clog2(DEPTH)+1  number of queued entries.
underflow_err  output  1  sticky: resp_valid arrived with no load to match.

Behaviour:
- Storage: circular FIFO of DEPTH rd entries with write pointer, read pointer and count; pointers wrap modulo DEPTH.
- Reset (rst_n low, asynchronous): pointers=0, count=0, underflow_err=0, contents don't-care. Resulting outputs: pending_mask=0, hazard=0, issue_ready=1.
- Accepted issue: issue_valid && issue_ready. Issuing while full is a protocol violation; the entry is dropped and state is unchanged.
- Write-back select (combinational, same cycle):
  - resp_valid && count>0: wb_rd = head entry, wb_is_load=1; head pops at the clock edge.
  - resp_valid && count==0 && issue_valid: zero-latency bypass. wb_rd = issue_rd, wb_is_load=1, nothing is enqueued.
  - resp_valid && count==0 && !issue_valid: wb_rd = wb_rd_in, wb_is_load=0; underflow_err sets on the next edge and stays set until reset.
  - !resp_valid: wb_rd = wb_rd_in, wb_is_load=0.
- Pop and push in the same cycle with count>0: both occur; count is unchanged and results stay in order, so the new entry is behind the head.
- Full with simultaneous resp_valid: issue_ready stays 0. There is no same-cycle slot reuse.
- flush: at the edge, count=0 and rptr=wptr. A same-cycle issue is discarded. A same-cycle resp_valid with count>0 still drives wb_rd from the head this cycle (combinational). flush does not clear underflow_err.
- pending_mask: OR of one-hot decodes of all valid entries, combinational from current state. Entries targeting register 0 are queued but never flagged.
- hazard = pending_mask[query_rs1] | pending_mask[query_rs2]. Combinational; does not include the issuing load of the same cycle.
- Latency: wb_rd is combinational. count, pointers and pending_mask update one cycle after an accepted issue or pop.
- Duplicate rd in several entries is allowed. The mask bit stays set until the last matching entry pops.

Test Plan:
- Reset then idle: pending_mask=0, hazard=0, count=0, issue_ready=1. Assert rst_n low mid-sequence with 3 entries queued -> count=0, pending_mask=0 immediately, before any clock edge.
- Issue rd=5, 6, 7 on consecutive cycles, then resp_valid for 3 cycles -> wb_rd=5,6,7 with wb_is_load=1. pending_mask bits 5/6/7 clear one cycle after each pop; query_rs1=6 -> hazard=1 until the second pop.
- Fill DEPTH=4 (rd 1..4) -> issue_ready=0. Issue rd=9 while full -> ignored, count=4, bit 9 clear. Drain all four and verify order 1,2,3,4.
- count=0, issue_valid with rd=12 and resp_valid in the same cycle -> wb_rd=12, wb_is_load=1, count stays 0. At count=2, simultaneous push rd=8 and pop -> count=2, head advances, 8 returns last.
- resp_valid at count=0 with no issue -> wb_rd=wb_rd_in, wb_is_load=0, underflow_err=1 next cycle and persists through a flush.
- Queue rd=0 and rd=3, then flush -> pending_mask bit 0 never set. After the flush count=0, bit 3 clear, and the next issue rd=10 pops first.
